// File: rtl/neuron_tm_pe_if.sv
// Update/result channel of the time-multiplexed LIF processing element.
// The slave side is the PE. The master side is the upstream MAC stage, which also observes the results.
interface neuron_tm_pe_if #(
  parameter int NUM_NEURONS = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int SUM_WIDTH   = 16
);
  localparam int NID_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  logic                  i_valid;
  logic                  o_ready;
  logic [NID_W-1:0]      i_nid;
  logic                  i_start;
  logic [SUM_WIDTH-1:0]  i_mac_sum;
  logic                  o_valid;
  logic [NID_W-1:0]      o_nid;
  logic                  o_spike;
  logic [DATA_WIDTH-1:0] o_vmem;

  modport master (
    output i_valid, i_nid, i_start, i_mac_sum,
    input  o_ready, o_valid, o_nid, o_spike, o_vmem
  );

  modport slave (
    input  i_valid, i_nid, i_start, i_mac_sum,
    output o_ready, o_valid, o_nid, o_spike, o_vmem
  );
endinterface

// File: rtl/neuron_tm_pe.sv
// Time-multiplexed LIF processing element with internal {vmem, fsm} storage and a clear sweep.
// Optional: define SPIKE_COUNT_EN to add a 32-bit o_spike_count output.
module neuron_tm_pe #(
  parameter int NUM_NEURONS = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int SUM_WIDTH   = 16,
  parameter int THRESH      = 15,
  parameter int THRESH_HIGH = 40,
  parameter int MAX_VAL     = 100,
  parameter int LEAK_IDLE   = 2,
  parameter int LEAK_REF    = 20,
  parameter int ABS_EXIT    = 70
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_clear,
  neuron_tm_pe_if.slave       io_pe
`ifdef SPIKE_COUNT_EN
  ,
  output logic [31:0]         o_spike_count
`endif
);
  localparam int NID_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int XW    = SUM_WIDTH + 1;

  localparam logic [XW-1:0]         C_LEAK_IDLE   = XW'(LEAK_IDLE);
  localparam logic [XW-1:0]         C_LEAK_REF    = XW'(LEAK_REF);
  localparam logic [XW-1:0]         C_THRESH      = XW'(THRESH);
  localparam logic [XW-1:0]         C_THRESH_HIGH = XW'(THRESH_HIGH);
  localparam logic [XW-1:0]         C_MAX         = XW'(MAX_VAL);
  localparam logic [XW-1:0]         C_ABS_EXIT    = XW'(ABS_EXIT);
  localparam logic [DATA_WIDTH-1:0] C_MAX_V       = DATA_WIDTH'(MAX_VAL);
  localparam logic [DATA_WIDTH-1:0] C_LEAK_REF_V  = DATA_WIDTH'(LEAK_REF);
  localparam logic [NID_W-1:0]      C_LAST_IDX    = NID_W'(NUM_NEURONS - 1);
  localparam logic [NID_W:0]        C_NUM_N       = (NID_W+1)'(NUM_NEURONS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SPIKE   = 2'd1,
    ST_REL_REF = 2'd2,
    ST_ABS_REF = 2'd3
  } state_t;

  state_t                r_fsm  [NUM_NEURONS];
  logic [DATA_WIDTH-1:0] r_vmem [NUM_NEURONS];

  logic                  r_sweep;
  logic [NID_W-1:0]      r_sweep_idx;

  logic                  r_s1_valid;
  logic [NID_W-1:0]      r_s1_nid;
  logic                  r_s1_start;
  logic [SUM_WIDTH-1:0]  r_s1_sum;

  logic                  r_o_valid;
  logic [NID_W-1:0]      r_o_nid;
  logic                  r_o_spike;
  logic [DATA_WIDTH-1:0] r_o_vmem;

  logic                  w_accept;
  logic                  w_nid_ok;
  logic                  w_wr_en;
  logic [DATA_WIDTH-1:0] w_v;
  state_t                w_st;
  logic [XW-1:0]         w_vx;
  logic [XW-1:0]         w_t;
  logic [XW-1:0]         w_dec;
  logic [XW-1:0]         w_leak;
  logic [XW-1:0]         w_thr;
  logic [XW-1:0]         w_u;
  logic [DATA_WIDTH-1:0] w_new_vmem;
  state_t                w_next_st;

  assign io_pe.o_ready = ~r_sweep;
  assign w_accept      = io_pe.i_valid & ~r_sweep;
  assign w_nid_ok      = ({1'b0, r_s1_nid} < C_NUM_N);
  assign w_wr_en       = r_s1_valid & w_nid_ok & ~rst;

  // Stage 1 reads the array after the previous update's writeback, so back-to-back updates see fresh state.
  always_comb begin
    w_v        = '0;
    w_st       = ST_IDLE;
    if (w_nid_ok) begin
      w_v  = r_vmem[r_s1_nid];
      w_st = r_fsm[r_s1_nid];
    end
    w_vx       = {{(XW-DATA_WIDTH){1'b0}}, w_v};
    w_t        = w_vx + {1'b0, r_s1_sum};
    w_leak     = (w_st == ST_IDLE) ? C_LEAK_IDLE : C_LEAK_REF;
    w_thr      = (w_st == ST_IDLE) ? C_THRESH : C_THRESH_HIGH;
    w_dec      = w_t - w_leak;
    w_u        = '0;
    if (r_s1_start) begin
      if (w_t > w_leak)
        w_u = (w_dec > C_MAX) ? C_MAX : w_dec;
    end else if (w_vx > w_leak) begin
      w_u = w_vx - w_leak;
    end

    w_new_vmem = w_v;
    w_next_st  = w_st;
    case (w_st)
      ST_IDLE: begin
        w_new_vmem = (w_vx < w_thr && w_u >= w_thr) ? C_MAX_V : w_u[DATA_WIDTH-1:0];
        if (w_vx >= C_THRESH) w_next_st = ST_SPIKE;
      end
      ST_SPIKE: begin
        w_next_st = ST_ABS_REF;
      end
      ST_ABS_REF: begin
        w_new_vmem = (w_v > C_LEAK_REF_V) ? (w_v - C_LEAK_REF_V) : '0;
        if (w_vx <= C_ABS_EXIT) w_next_st = ST_REL_REF;
      end
      ST_REL_REF: begin
        w_new_vmem = (w_vx < w_thr && w_u >= w_thr) ? C_MAX_V : w_u[DATA_WIDTH-1:0];
        if (w_v == '0)
          w_next_st = ST_IDLE;
        else if (w_vx >= C_THRESH_HIGH && r_s1_start)
          w_next_st = ST_SPIKE;
      end
      default: begin
        w_next_st = ST_IDLE;
      end
    endcase
  end

  // Pipeline, output registers and the sweep controller; i_clear never drops an in-flight update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sweep     <= 1'b1;
      r_sweep_idx <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_nid    <= '0;
      r_s1_start  <= 1'b0;
      r_s1_sum    <= '0;
      r_o_valid   <= 1'b0;
      r_o_nid     <= '0;
      r_o_spike   <= 1'b0;
      r_o_vmem    <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_nid   <= io_pe.i_nid;
        r_s1_start <= io_pe.i_start;
        r_s1_sum   <= io_pe.i_mac_sum;
      end
      r_o_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_o_nid   <= r_s1_nid;
        r_o_spike <= w_nid_ok && (w_st == ST_SPIKE);
        r_o_vmem  <= w_nid_ok ? w_new_vmem : '0;
      end
      if (i_clear) begin
        r_sweep     <= 1'b1;
        r_sweep_idx <= '0;
      end else if (r_sweep) begin
        if (r_sweep_idx == C_LAST_IDX) begin
          r_sweep     <= 1'b0;
          r_sweep_idx <= '0;
        end else begin
          r_sweep_idx <= r_sweep_idx + 1'b1;
        end
      end
    end
  end

  // A sweep write wins over an update writeback landing on the same index in the same cycle.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_NEURONS; i++) begin
      if (r_sweep && r_sweep_idx == NID_W'(i)) begin
        r_vmem[i] <= '0;
        r_fsm[i]  <= ST_IDLE;
      end else if (w_wr_en && r_s1_nid == NID_W'(i)) begin
        r_vmem[i] <= w_new_vmem;
        r_fsm[i]  <= w_next_st;
      end
    end
  end

  assign io_pe.o_valid = r_o_valid;
  assign io_pe.o_nid   = r_o_nid;
  assign io_pe.o_spike = r_o_spike;
  assign io_pe.o_vmem  = r_o_vmem;

`ifdef SPIKE_COUNT_EN
  logic [31:0] r_spike_count;

  always_ff @(posedge clk) begin
    if (rst || i_clear)
      r_spike_count <= '0;
    else if (r_o_valid && r_o_spike)
      r_spike_count <= r_spike_count + 32'd1;
  end

  assign o_spike_count = r_spike_count;
`endif
endmodule

// File: tb/tb_neuron_tm_pe.sv
// Directed self-checking bench for neuron_tm_pe: reset sweep, fire/refractory chain, saturation, hazards, clear.
module tb_neuron_tm_pe;
  localparam int NUM_NEURONS = 16;
  localparam int DATA_WIDTH  = 8;
  localparam int SUM_WIDTH   = 16;

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic i_clear = 1'b0;
  int   assertCount = 0;
  int   failCount   = 0;
  int   lowCount;

  always #5 clk = ~clk;

  neuron_tm_pe_if #(
    .NUM_NEURONS(NUM_NEURONS), .DATA_WIDTH(DATA_WIDTH), .SUM_WIDTH(SUM_WIDTH)
  ) pe_bus ();

`ifdef SPIKE_COUNT_EN
  logic [31:0] spikeCount;
`endif

  neuron_tm_pe #(
    .NUM_NEURONS(NUM_NEURONS), .DATA_WIDTH(DATA_WIDTH), .SUM_WIDTH(SUM_WIDTH),
    .THRESH(15), .THRESH_HIGH(40), .MAX_VAL(100),
    .LEAK_IDLE(2), .LEAK_REF(20), .ABS_EXIT(70)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_clear(i_clear),
    .io_pe(pe_bus)
`ifdef SPIKE_COUNT_EN
    ,
    .o_spike_count(spikeCount)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Waits (bounded) at negedges until the PE can accept.
  task automatic waitReady(input string tag);
    int n = 0;
    while (pe_bus.o_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_ready"}, 32'(pe_bus.o_ready), 32'd1);
  endtask

  // One isolated update: drive at a negedge, check 2-edge latency and the result fields.
  task automatic applyStimulus(input logic [3:0] nid, input logic start, input logic [15:0] mac,
                               input logic expSpike, input logic [7:0] expVmem, input string tag);
    waitReady(tag);
    pe_bus.i_valid   = 1'b1;
    pe_bus.i_nid     = nid;
    pe_bus.i_start   = start;
    pe_bus.i_mac_sum = mac;
    @(posedge clk);
    @(negedge clk);
    pe_bus.i_valid   = 1'b0;
    pe_bus.i_start   = 1'b0;
    pe_bus.i_mac_sum = '0;
    checkOutput({tag, "_early"}, 32'(pe_bus.o_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "_valid"}, 32'(pe_bus.o_valid), 32'd1);
    checkOutput({tag, "_nid"},   32'(pe_bus.o_nid),   32'(nid));
    checkOutput({tag, "_spike"}, 32'(pe_bus.o_spike), 32'(expSpike));
    checkOutput({tag, "_vmem"},  32'(pe_bus.o_vmem),  32'(expVmem));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    pe_bus.i_valid   = 1'b0;
    pe_bus.i_nid     = '0;
    pe_bus.i_start   = 1'b0;
    pe_bus.i_mac_sum = '0;

    // Reset, then count the cycles the sweep holds o_ready low.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_o_valid", 32'(pe_bus.o_valid), 32'd0);
    checkOutput("rst_o_nid",   32'(pe_bus.o_nid),   32'd0);
    checkOutput("rst_o_spike", 32'(pe_bus.o_spike), 32'd0);
    checkOutput("rst_o_vmem",  32'(pe_bus.o_vmem),  32'd0);
    lowCount = 0;
    while (pe_bus.o_ready !== 1'b1 && lowCount < 64) begin
      lowCount++;
      @(negedge clk);
    end
    checkOutput("rst_ready_low_cycles", 32'(lowCount), 32'd16);

    applyStimulus(4'd0,  1'b0, 16'd0, 1'b0, 8'd0, "rstRead0");
    applyStimulus(4'd15, 1'b0, 16'd0, 1'b0, 8'd0, "rstRead15");
    applyStimulus(4'd3,  1'b0, 16'd0, 1'b0, 8'd0, "rstRead3");

    // Fire, absolute/relative refractory, re-fire chain on neuron 3.
    applyStimulus(4'd3, 1'b1, 16'd20, 1'b0, 8'd100, "fire1");
    applyStimulus(4'd3, 1'b0, 16'd0,  1'b0, 8'd98,  "fire2");
    applyStimulus(4'd3, 1'b0, 16'd0,  1'b1, 8'd98,  "fire3");
    applyStimulus(4'd3, 1'b0, 16'd0,  1'b0, 8'd78,  "fire4");
    applyStimulus(4'd3, 1'b0, 16'd0,  1'b0, 8'd58,  "fire5");
    applyStimulus(4'd3, 1'b0, 16'd0,  1'b0, 8'd38,  "fire6");
    applyStimulus(4'd3, 1'b1, 16'd12, 1'b0, 8'd30,  "rel30");
    applyStimulus(4'd3, 1'b1, 16'd30, 1'b0, 8'd100, "relCross");
    applyStimulus(4'd3, 1'b1, 16'd5,  1'b0, 8'd85,  "refire1");
    applyStimulus(4'd3, 1'b0, 16'd0,  1'b1, 8'd85,  "refire2");
    applyStimulus(4'd3, 1'b0, 16'd0,  1'b0, 8'd65,  "abs65");
    applyStimulus(4'd3, 1'b0, 16'd0,  1'b0, 8'd45,  "rel45");
    applyStimulus(4'd3, 1'b1, 16'd0,  1'b0, 8'd25,  "refire45");
    applyStimulus(4'd3, 1'b0, 16'd0,  1'b1, 8'd25,  "spike25");
`ifdef SPIKE_COUNT_EN
    @(negedge clk);
    checkOutput("spikeCount_after_fire", spikeCount, 32'd3);
`endif

    // Saturation of a full-scale sum and the zero floor of the leak.
    applyStimulus(4'd7, 1'b1, 16'hFFFF, 1'b0, 8'd100, "saturate");
    applyStimulus(4'd8, 1'b1, 16'd3,    1'b0, 8'd1,   "small1");
    applyStimulus(4'd8, 1'b0, 16'd0,    1'b0, 8'd0,   "floor0");

    // Back-to-back updates to neuron 5 must chain through fresh state: 3, 6, 9.
    waitReady("hazard");
    pe_bus.i_valid   = 1'b1;
    pe_bus.i_nid     = 4'd5;
    pe_bus.i_start   = 1'b1;
    pe_bus.i_mac_sum = 16'd5;
    @(posedge clk);
    @(negedge clk);
    checkOutput("hazard_early", 32'(pe_bus.o_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("hazard1_valid", 32'(pe_bus.o_valid), 32'd1);
    checkOutput("hazard1_vmem",  32'(pe_bus.o_vmem),  32'd3);
    @(posedge clk);
    @(negedge clk);
    pe_bus.i_valid = 1'b0;
    pe_bus.i_start = 1'b0;
    checkOutput("hazard2_valid", 32'(pe_bus.o_valid), 32'd1);
    checkOutput("hazard2_vmem",  32'(pe_bus.o_vmem),  32'd6);
    @(posedge clk);
    @(negedge clk);
    checkOutput("hazard3_valid", 32'(pe_bus.o_valid), 32'd1);
    checkOutput("hazard3_vmem",  32'(pe_bus.o_vmem),  32'd9);
    @(posedge clk);
    @(negedge clk);
    checkOutput("hazard_idle", 32'(pe_bus.o_valid), 32'd0);

    // Clear while neurons 1 and 2 are in flight.
    applyStimulus(4'd1, 1'b1, 16'd10, 1'b0, 8'd8, "pre1");
    applyStimulus(4'd2, 1'b1, 16'd9,  1'b0, 8'd7, "pre2");
    waitReady("clear");
    pe_bus.i_valid   = 1'b1;
    pe_bus.i_nid     = 4'd1;
    pe_bus.i_start   = 1'b0;
    pe_bus.i_mac_sum = '0;
    @(posedge clk);
    @(negedge clk);
    pe_bus.i_nid = 4'd2;
    i_clear      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pe_bus.i_valid = 1'b0;
    i_clear        = 1'b0;
    checkOutput("clr_r1_valid", 32'(pe_bus.o_valid), 32'd1);
    checkOutput("clr_r1_nid",   32'(pe_bus.o_nid),   32'd1);
    checkOutput("clr_r1_vmem",  32'(pe_bus.o_vmem),  32'd6);
    lowCount = 0;
    if (pe_bus.o_ready !== 1'b1) lowCount++;
    @(posedge clk);
    @(negedge clk);
    checkOutput("clr_r2_valid", 32'(pe_bus.o_valid), 32'd1);
    checkOutput("clr_r2_nid",   32'(pe_bus.o_nid),   32'd2);
    checkOutput("clr_r2_vmem",  32'(pe_bus.o_vmem),  32'd5);
    if (pe_bus.o_ready !== 1'b1) lowCount++;
    @(negedge clk);
    while (pe_bus.o_ready !== 1'b1 && lowCount < 64) begin
      lowCount++;
      @(negedge clk);
    end
    checkOutput("clr_ready_low_cycles", 32'(lowCount), 32'd16);
`ifdef SPIKE_COUNT_EN
    checkOutput("spikeCount_after_clear", spikeCount, 32'd0);
`endif
    applyStimulus(4'd1, 1'b0, 16'd0, 1'b0, 8'd0, "postClr1");
    applyStimulus(4'd2, 1'b1, 16'd3, 1'b0, 8'd1, "postClr2");
    applyStimulus(4'd3, 1'b0, 16'd0, 1'b0, 8'd0, "postClr3");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
